alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised successor to the 8-bit bus adder. Holds operands A and B loaded from the shared bus `w`. Executes one of eight operations (add, subtract, logic, shift, multi-cycle unsigned multiply) and registers the result and status flags. Drives the result back onto the bus on request. Sits on the CPU data bus in place of the adder, under control of the sequencer.

## Interface

Parameters:
- `WIDTH`, 8: datapath and bus width; legal values are 4 and up.
- `CNT_W`, `$clog2(WIDTH+1)`: width of the multiply iteration counter; derived, not overridden.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `w`  inout  WIDTH  shared bus; high-Z unless `ea` or `eh` is driving.
- `la`  in  1  load A from `w`.
- `lb`  in  1  load B from `w`.
- `op`  in  3  operation select, sampled with `ev`.
- `ev`  in  1  execute; single-cycle start pulse.
- `ea`  in  1  drive result low word R onto `w`.
- `eh`  in  1  drive multiply high word H onto `w`.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle pulse when R and flags update.
- `cout`  out  1  carry flag, registered.
- `zero`  out  1  zero flag, registered.
- `neg`  out  1  negative flag (R[MSB]), registered.
- `ovf`  out  1  signed overflow flag, registered.

## Operation

- Reset (`clr`=0): A, B, R, H, counter, all flags, `busy` and `done` go to 0. State goes to IDLE. `w` is released.
- Operand load: `la`/`lb` high at an edge in IDLE loads `w` into A/B. Loads while `busy` are ignored.
- `ev` in IDLE starts `op`. `ev` while `busy` is ignored; the `op` value is dropped.
- Operations; each writes R, H=0 except MUL, and flags:
  - 000 ADD: R=A+B. `cout`=carry out. `ovf`=signed overflow.
  - 001 SUB: R=A+~B+1. `cout`=1 means no borrow. `ovf`=signed overflow.
  - 010 AND, 011 OR, 100 XOR: `cout`=0, `ovf`=0.
  - 101 SHL: R=A<<1. `cout`=A[MSB]. `ovf`=0.
  - 110 SHR (logical): R=A>>1. `cout`=A[0]. `ovf`=0.
  - 111 MUL (unsigned shift-add): {H,R}=A*B. `cout`=(H!=0). `ovf`=0.
- Flag rules:
  - `zero`=(R==0). For MUL, `zero`=({H,R}==0).
  - `neg`=R[WIDTH-1] for every operation.
- States:
  - IDLE --ev&op=111--> MUL: operands copied to working registers, product accumulator cleared, counter=WIDTH.
  - MUL does one add/shift per cycle and decrements the counter.
  - MUL --counter reaches 0--> IDLE: H, R and flags are written.
  - All other operations complete in IDLE.
- Bus:
  - `ea`=1 drives R. `eh`=1 drives H. `ea` has priority if both are high.
  - Driving is allowed while `busy`; it shows the last completed R/H.
  - The block never loads from `w` in the same cycle it drives `w`: `la`/`lb` are ignored while `ea` or `eh` is high.
- A and B are never modified by execution. The same operands may be re-executed.

## Timing

- `ev` sampled at edge k, op != MUL:
  - R, H and flags are valid after edge k.
  - `done`=1 for the cycle between edges k and k+1.
  - Back-to-back `ev` on consecutive edges is legal; each produces its own `done`.
- `ev` sampled at edge k, op = MUL:
  - `busy`=1 from edge k to edge k+WIDTH.
  - R/H/flags are written at edge k+WIDTH.
  - `done`=1 for the cycle after edge k+WIDTH.
  - `busy` and `done` are never high together.
- `ev` at the edge where `busy` falls is ignored. The next accepted start is at edge k+WIDTH+1.
- `clr` low mid-MUL: the operation is abandoned immediately. R/H/flags go to 0, and no `done` is produced.
- Flags hold their values until the next completed operation.
- `w` tri-state is combinational from `ea`/`eh`.

## Test plan

- ADD overflow (WIDTH=8): load A=0x7F, B=0x01, `ev` with op=000 -> R=0x80, `cout`=0, `ovf`=1, `neg`=1, `zero`=0, `done` for 1 cycle. Then load B=0x81 (A=0x7F), ADD -> R=0x00, `cout`=1, `zero`=1.
- SUB borrow: A=0x05, B=0x07, op=001 -> R=0xFE, `cout`=0, `neg`=1, `ovf`=0. Then A=0x80, B=0x01 -> R=0x7F, `ovf`=1, `cout`=1.
- Logic and shift: A=0xA5, B=0x0F:
  - AND -> 0x05.
  - OR -> 0xAF.
  - XOR -> 0xAA.
  - SHL -> 0x4A with `cout`=1.
  - SHR -> 0x52 with `cout`=1.
  - `ovf`=0 for all five.
- MUL: A=0xFF, B=0xFF, `ev` at edge k -> `busy` high for 8 cycles, `done` after edge k+8. R=0x01, H=0xFE, `cout`=1. `ev`/`la` pulsed mid-multiply are ignored. `ea` then `eh` put 0x01 then 0xFE on `w`.
- MUL zero and reset: A=0x00, B=0x37, MUL -> R=H=0, `zero`=1, `cout`=0. Restart with A=0x0F, B=0x11 and assert `clr` at edge k+3 -> all outputs 0, no `done`. After reset, the same MUL gives R=0xFF, H=0x00.
- Bus release and priority: `ea`=`eh`=0 -> `w` is Z. `ea`=`eh`=1 -> `w`=R. `la` with `ea`=1 -> A unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// Bus-attached ALU: holds operands A/B loaded from w, executes one of eight ops,
// registers R/H and status flags, and drives R or H back onto w on request.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    inout  wire  [WIDTH-1:0] w,
    input  logic             la,
    input  logic             lb,
    input  logic [2:0]       op,
    input  logic             ev,
    input  logic             ea,
    input  logic             eh,
    output logic             busy,
    output logic             done,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     r;
    logic [WIDTH-1:0]     h;
    logic [2*WIDTH-1:0]   ma;
    logic [WIDTH-1:0]     mb;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       sub_s;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c;
    logic                 alu_v;
    logic [2*WIDTH-1:0]   acc_next;

    // ea wins over eh; bus is released whenever neither is asserted.
    assign w = ea ? r : (eh ? h : {WIDTH{1'bz}});

    always_comb begin
        add_s    = {1'b0, a} + {1'b0, b};
        sub_s    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        acc_next = acc + (mb[0] ? ma : '0);
        alu_r    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            3'b000: begin
                alu_r = add_s[MSB:0];
                alu_c = add_s[WIDTH];
                alu_v = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
            end
            3'b001: begin
                alu_r = sub_s[MSB:0];
                alu_c = sub_s[WIDTH];
                alu_v = (a[MSB] != b[MSB]) && (sub_s[MSB] != a[MSB]);
            end
            3'b010: alu_r = a & b;
            3'b011: alu_r = a | b;
            3'b100: alu_r = a ^ b;
            3'b101: begin
                alu_r = {a[MSB-1:0], 1'b0};
                alu_c = a[MSB];
            end
            3'b110: begin
                alu_r = {1'b0, a[MSB:1]};
                alu_c = a[0];
            end
            default: alu_r = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
            a     <= '0;
            b     <= '0;
            r     <= '0;
            h     <= '0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cout  <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Never capture w in a cycle where this block is driving it.
                    if (!(ea || eh)) begin
                        if (la) a <= w;
                        if (lb) b <= w;
                    end
                    if (ev) begin
                        if (op == 3'b111) begin
                            ma    <= {{WIDTH{1'b0}}, a};
                            mb    <= b;
                            acc   <= '0;
                            cnt   <= CNT_W'(WIDTH);
                            busy  <= 1'b1;
                            state <= S_MUL;
                        end else begin
                            r    <= alu_r;
                            h    <= '0;
                            cout <= alu_c;
                            ovf  <= alu_v;
                            zero <= (alu_r == '0);
                            neg  <= alu_r[MSB];
                            done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= acc_next;
                    ma  <= ma << 1;
                    mb  <= mb >> 1;
                    cnt <= cnt - CNT_W'(1);
                    // Last add/shift: commit the full product this edge.
                    if (cnt == CNT_W'(1)) begin
                        r     <= acc_next[MSB:0];
                        h     <= acc_next[2*WIDTH-1:WIDTH];
                        cout  <= |acc_next[2*WIDTH-1:WIDTH];
                        zero  <= (acc_next == '0);
                        neg   <= acc_next[MSB];
                        ovf   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): expected results are queued at each
// start and checked when done pulses; bus reads go through ea/eh.
module tb_alu_seq;

    logic       clk;
    logic       clr;
    wire  [7:0] w;
    logic [7:0] tb_w;
    logic       tb_we;
    logic       la, lb, ev, ea, eh;
    logic [2:0] op;
    logic       busy, done, cout, zero, neg, ovf;

    logic [19:0] exp_q[$];
    logic [7:0]  a_m, b_m;
    int          total, bad, n;

    assign w = tb_we ? tb_w : 8'bz;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .clr(clr), .w(w), .la(la), .lb(lb), .op(op), .ev(ev),
        .ea(ea), .eh(eh), .busy(busy), .done(done), .cout(cout),
        .zero(zero), .neg(neg), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Packed as {r[19:12], h[11:4], cout, zero, neg, ovf}.
    function automatic logic [19:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        logic [7:0]  rr, hh;
        logic        c, v;
        int          s;
        rr = 8'h00; hh = 8'h00; c = 1'b0; v = 1'b0;
        case (o)
            3'd0: begin
                p = 16'(x) + 16'(y); rr = p[7:0]; c = p[8];
                s = int'($signed(x)) + int'($signed(y)); v = (s > 127) || (s < -128);
            end
            3'd1: begin
                p = 16'(x) - 16'(y); rr = p[7:0]; c = (x >= y);
                s = int'($signed(x)) - int'($signed(y)); v = (s > 127) || (s < -128);
            end
            3'd2: rr = x & y;
            3'd3: rr = x | y;
            3'd4: rr = x ^ y;
            3'd5: begin p = 16'(x) * 16'd2; rr = p[7:0]; c = p[8]; end
            3'd6: begin rr = x / 8'd2; c = x[0]; end
            default: begin p = 16'(x) * 16'(y); rr = p[7:0]; hh = p[15:8]; c = (hh != 8'h00); end
        endcase
        return {rr, hh, c, (rr == 8'h00) && (hh == 8'h00), rr[7], v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        tb_w = v; tb_we = 1'b1; la = 1'b1;
        tick();
        la = 1'b0; tb_we = 1'b0; a_m = v;
    endtask

    task automatic load_b(input logic [7:0] v);
        tb_w = v; tb_we = 1'b1; lb = 1'b1;
        tick();
        lb = 1'b0; tb_we = 1'b0; b_m = v;
    endtask

    task automatic start_op(input logic [2:0] o);
        op = o; ev = 1'b1;
        exp_q.push_back(model(o, a_m, b_m));
        tick();
        ev = 1'b0;
    endtask

    task automatic check_now();
        logic [19:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 16'd0, 16'd1);
            return;
        end
        e = exp_q.pop_front();
        chk("busy_with_done", 16'(busy), 16'd0);
        chk("cout", 16'(cout), 16'(e[3]));
        chk("zero", 16'(zero), 16'(e[2]));
        chk("neg",  16'(neg),  16'(e[1]));
        chk("ovf",  16'(ovf),  16'(e[0]));
        ea = 1'b1; #1;
        chk("r", 16'(w), 16'(e[19:12]));
        ea = 1'b0; eh = 1'b1; #1;
        chk("h", 16'(w), 16'(e[11:4]));
        eh = 1'b0; #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("done_seen", 16'(done), 16'd1);
        if (done) check_now();
        else if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    initial begin
        total = 0; bad = 0;
        clr = 1'b0; la = 0; lb = 0; ev = 0; ea = 0; eh = 0; op = 3'd0;
        tb_w = 8'h00; tb_we = 1'b0; a_m = 8'h00; b_m = 8'h00;
        tick(); tick();
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_flags", 16'({cout, zero, neg, ovf}), 16'd0);
        ea = 1'b1; #1; chk("rst_r", 16'(w), 16'd0);
        ea = 1'b0; eh = 1'b1; #1; chk("rst_h", 16'(w), 16'd0);
        eh = 1'b0;
        clr = 1'b1;
        tick();

        // ADD overflow, then ADD wrapping to zero
        load_a(8'h7F); load_b(8'h01);
        start_op(3'd0); wait_done(n); chk("add_lat", 16'(n), 16'd0);
        tick(); chk("done_pulse", 16'(done), 16'd0);
        load_b(8'h81);
        start_op(3'd0); wait_done(n);

        // SUB borrow and signed overflow
        load_a(8'h05); load_b(8'h07);
        start_op(3'd1); wait_done(n);
        load_a(8'h80); load_b(8'h01);
        start_op(3'd1); wait_done(n);

        // Logic and shifts, AND/OR issued back to back
        load_a(8'hA5); load_b(8'h0F);
        op = 3'd2; ev = 1'b1;
        exp_q.push_back(model(3'd2, a_m, b_m));
        tick();
        op = 3'd3;
        exp_q.push_back(model(3'd3, a_m, b_m));
        chk("b2b_done1", 16'(done), 16'd1);
        check_now();
        tick();
        ev = 1'b0;
        chk("b2b_done2", 16'(done), 16'd1);
        check_now();
        for (int i = 4; i <= 6; i++) begin
            start_op(3'(i)); wait_done(n);
        end

        // MUL 0xFF*0xFF with ignored ev/la mid-run and ev at the busy-fall edge
        load_a(8'hFF); load_b(8'hFF);
        start_op(3'd7);
        chk("mul_busy0", 16'(busy), 16'd1);
        for (int i = 1; i < 8; i++) begin
            if (i == 3) begin
                ev = 1'b1; op = 3'd0; la = 1'b1; tb_we = 1'b1; tb_w = 8'h12;
            end
            tick();
            ev = 1'b0; la = 1'b0; tb_we = 1'b0;
            chk("mul_busy", 16'(busy), 16'd1);
            chk("mul_nodone", 16'(done), 16'd0);
        end
        ev = 1'b1; op = 3'd0;
        tick();
        ev = 1'b0;
        chk("mul_done_k8", 16'(done), 16'd1);
        if (done) check_now();
        else if (exp_q.size() != 0) void'(exp_q.pop_front());
        tick();
        chk("mul_ev_ignored", 16'(done), 16'd0);
        chk("mul_busy_off", 16'(busy), 16'd0);

        // Bus priority and load suppressed while driving
        ea = 1'b1; eh = 1'b1; #1;
        chk("bus_prio", 16'(w), 16'h0001);
        eh = 1'b0; la = 1'b1;
        tick();
        la = 1'b0; ea = 1'b0;
        start_op(3'd0); wait_done(n);

        // MUL zero
        load_a(8'h00); load_b(8'h37);
        start_op(3'd7); wait_done(n); chk("mul_lat", 16'(n), 16'd8);

        // Reset mid-multiply
        load_a(8'h0F); load_b(8'h11);
        start_op(3'd7);
        tick(); tick();
        @(posedge clk);
        clr = 1'b0;
        void'(exp_q.pop_back());
        a_m = 8'h00; b_m = 8'h00;
        #1;
        chk("clr_busy", 16'(busy), 16'd0);
        chk("clr_flags", 16'({done, cout, zero, neg, ovf}), 16'd0);
        ea = 1'b1; #1; chk("clr_r", 16'(w), 16'd0);
        ea = 1'b0; eh = 1'b1; #1; chk("clr_h", 16'(w), 16'd0);
        eh = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) clr = 1'b1;
            chk("clr_nodone", 16'(done), 16'd0);
        end
        load_a(8'h0F); load_b(8'h11);
        start_op(3'd7); wait_done(n);

        // Random operand/op mix
        for (int i = 0; i < 10; i++) begin
            load_a(8'($urandom_range(0, 255)));
            load_b(8'($urandom_range(0, 255)));
            start_op(3'($urandom_range(0, 7)));
            wait_done(n);
        end

        chk("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
